// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_sequencer_pkg;
  localparam logic OP_MULU = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  localparam int ITER_CYCLES = 32;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/muldiv_sequencer_rca.sv
// Plain ripple-carry adder; the sequencer's only arithmetic resource.
module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[WIDTH];
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Shift-add unsigned multiplier and restoring divider sharing one adder,
// sequenced by a four-state FSM with a 5-bit down-counter.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// LOAD  | working register initialised, counter loaded with 31
// ITER  | one multiply/divide step per cycle, 32 cycles
// DONE  | one-cycle done pulse, results valid
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DBZ_FAST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             dbz
);
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               op_q;
  logic [2*WIDTH-1:0] work;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [WIDTH-1:0]   rem_sh;
  logic               take;
  logic [WIDTH:0]     mul_hi;
  logic [2*WIDTH:0]   mul_cat;
  logic [2*WIDTH-1:0] mul_next, div_next, work_next;

  // Divide: {rem, quo} shifted left; the bit shifted out of rem forces a take.
  assign rem_sh  = work[2*WIDTH-2:WIDTH-1];
  assign add_a   = (op_q == OP_DIVU) ? rem_sh : work[2*WIDTH-1:WIDTH];
  assign add_b   = (op_q == OP_DIVU) ? ~b_q : b_q;
  assign add_cin = (op_q == OP_DIVU);

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign take     = add_cout | work[2*WIDTH-1];
  assign div_next = {(take ? add_sum : rem_sh), work[WIDTH-2:0], take};

  assign mul_hi    = work[0] ? {add_cout, add_sum} : {1'b0, work[2*WIDTH-1:WIDTH]};
  assign mul_cat   = {mul_hi, work[WIDTH-1:0]};
  assign mul_next  = mul_cat[2*WIDTH:1];
  assign work_next = (op_q == OP_DIVU) ? div_next : mul_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MULU;
      work      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          work <= {{WIDTH{1'b0}}, a_q};
          cnt  <= CNT_W'(ITER_CYCLES - 1);
          if (op_q == OP_DIVU && b_q == '0 && DBZ_FAST != 0) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            dbz       <= 1'b1;
            result_lo <= '1;
            result_hi <= a_q;
            state     <= ST_DONE;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          work <= work_next;
          if (cnt == '0) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            dbz       <= (op_q == OP_DIVU) && (b_q == '0);
            result_lo <= work_next[WIDTH-1:0];
            result_hi <= work_next[2*WIDTH-1:WIDTH];
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer plus abort/overlap/back-to-back sequences.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, dbz;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;

  int          lat, ovl, dones;
  logic [31:0] r_lo, r_hi;
  logic        r_dbz;

  muldiv_sequencer #(.WIDTH(32), .DBZ_FAST(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for done, counting cycles with the LOAD cycle as cycle 1.
  task automatic wait_done();
    lat = 1;
    ovl = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy && done) ovl++;
    end
    r_lo  = result_lo;
    r_hi  = result_hi;
    r_dbz = dbz;
  endtask

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    chk("busy_after_accept", busy, 1'b1);
    wait_done();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 34};
    vecs[1]  = '{1'b0, 32'd3,         32'd5,         32'd15,        32'd0,         1'b0, 34};
    vecs[2]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1,         1'b0, 34};
    vecs[3]  = '{1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 34};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'd2,         32'h0,         32'h1,         1'b0, 34};
    vecs[5]  = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'h0,         1'b0, 34};
    vecs[7]  = '{1'b1, 32'h1234,      32'h0,         32'hFFFF_FFFF, 32'h1234,      1'b1, 2};
    vecs[8]  = '{1'b1, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0, 34};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1,         32'h7FFF_FFFE, 1'b0, 34};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 32'h0,         1'b0, 34};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 34};

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", dbz, 1'b0);
    chk("rst_lo", result_lo, 32'h0);
    chk("rst_hi", result_hi, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_lo", i), r_lo, vecs[i].lo);
      chk($sformatf("v%0d_hi", i), r_hi, vecs[i].hi);
      chk($sformatf("v%0d_dbz", i), r_dbz, vecs[i].dbz);
      chk($sformatf("v%0d_excl", i), 64'(ovl), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_hold", i), {done, dbz, result_hi, result_lo},
          {1'b0, vecs[i].dbz, vecs[i].hi, vecs[i].lo});
    end

    // Second start during ITER must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int c = 2; c <= 50; c++) begin
      if (c == 10) begin
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
      end else if (c == 11) begin
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        lat = c;
      end
    end
    chk("ovr_dones", 64'(dones), 64'd1);
    chk("ovr_lat", 64'(lat), 64'd34);
    chk("ovr_lo", result_lo, 32'd15);
    chk("ovr_hi", result_hi, 32'd0);
    chk("ovr_dbz", dbz, 1'b0);

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {busy, done, dbz, result_hi, result_lo}, 67'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd7, 32'd6);
    chk("abort_re_lo", r_lo, 32'd42);
    chk("abort_re_hi", r_hi, 32'd0);
    chk("abort_re_lat", 64'(lat), 64'd34);

    // Back-to-back: start in the IDLE cycle following DONE.
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("b2b_first_lo", r_lo, 32'd15);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_hold_lo", result_lo, 32'd15);
    @(posedge clk); #20;
    chk("b2b_hold_mid", {result_hi, result_lo}, {32'd0, 32'd15});
    wait_done();
    chk("b2b_lo", r_lo, 32'd3);
    chk("b2b_hi", r_hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; 32 is the only supported value.
REQ-002 The block SHALL have parameter DBZ_FAST, default 1, which when set completes a divide-by-zero without iterating.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port op, input, 1 bit: 0 = MULU (unsigned multiply), 1 = DIVU (unsigned divide).
REQ-007 The block SHALL have port a, input, 32 bits: multiplicand or dividend.
REQ-008 The block SHALL have port b, input, 32 bits: multiplier or divisor.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in LOAD or ITER.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port result_lo, output, 32 bits: product low word or quotient.
REQ-012 The block SHALL have port result_hi, output, 32 bits: product high word or remainder.
REQ-013 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid while done is high and held afterwards.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, ITER and DONE.
- IDLE->LOAD when start=1.
- LOAD->ITER normally.
- LOAD->DONE for DIVU with b=0 when DBZ_FAST=1.
- ITER->DONE when the iteration count reaches 0.
- DONE->IDLE unconditionally.
REQ-015 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored and SHALL NOT alter operands or results.
REQ-016 a, b and op SHALL be captured on the accepting edge; later input changes SHALL NOT affect the running operation.
REQ-017 LOAD SHALL clear the working registers and load a 5-bit iteration counter with 31.
REQ-018 ITER SHALL last exactly 32 cycles, decrementing the counter once per cycle.
REQ-019 For MULU, each ITER cycle SHALL do the following:
- if product[0]=1, add b to product[63:32], keeping the carry-out;
- then shift {carry, product} right by 1.
REQ-020 For DIVU, each ITER cycle SHALL perform one restoring step:
- shift {rem, quo} left by 1;
- compute rem + ~b + 1;
- if carry-out=1, rem takes the difference and the new quo bit is 1;
- otherwise rem is kept and the new quo bit is 0.
REQ-021 All add/subtract operations SHALL use one shared 32-bit adder: operand B is muxed between b and ~b, and carry-in is 0 for add and 1 for subtract.
REQ-022 done SHALL be high exactly one cycle, in DONE, which is 34 cycles after the accepting edge (2 cycles for the fast divide-by-zero path).
REQ-023 result_lo and result_hi SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-024 DIVU with b=0 SHALL produce result_lo=0xFFFFFFFF, result_hi=a and dbz=1.
REQ-025 dbz SHALL be 0 for all MULU operations and for DIVU with b≠0.
REQ-026 busy and done SHALL never be high in the same cycle.
REQ-027 Operands SHALL wrap-free: the full 64-bit product is returned, with no overflow or truncation.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously enter IDLE, regardless of current state (including mid-ITER), abandoning any operation in progress.
REQ-029 On rst_n=0, busy, done, dbz, result_lo, result_hi and the counter SHALL all be 0.
REQ-030 After rst_n is deasserted, the first rising clk edge with start=1 SHALL be accepted.

Structure
REQ-031 A shared package SHALL hold:
- the op encodings OP_MULU=0 and OP_DIVU=1;
- the FSM state encodings;
- ITER_CYCLES=32.
REQ-032 The shared adder SHALL be one instance of the existing RippleCarryAdder; the block SHALL contain no other sub-module.

Verification
REQ-033 MULU with a=0xFFFFFFFF, b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, dbz=0, done 34 cycles after accept.
REQ-034 DIVU with a=100, b=7 -> result_lo=14, result_hi=2, dbz=0. DIVU with a=0x80000000, b=1 -> result_lo=0x80000000, result_hi=0.
REQ-035 DIVU with a=0x1234, b=0 and DBZ_FAST=1 -> result_lo=0xFFFFFFFF, result_hi=0x1234, dbz=1, done 2 cycles after accept.
REQ-036 Start MULU 3*5, then pulse start with DIVU 9/3 at cycle 10 -> second request ignored, result_lo=15, result_hi=0, exactly one done pulse.
REQ-037 Drop rst_n at cycle 10 of a MULU -> busy, done and results go to 0 immediately; a new start after release gives the correct result.
REQ-038 Back-to-back: start asserted in the cycle after done -> accepted, busy rises on the next cycle, and the prior results hold until the new DONE.
